// File: rtl/coin_dispenser.sv
// rtl/coin_dispenser.sv - coin dispenser sequencer
// Ejects quarters, then dimes, then nickels with ack handshake, inter-coin gap and ack timeout.
module coin_dispenser #(
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] q_cnt,
    input  logic [3:0] d_cnt,
    input  logic [3:0] n_cnt,
    input  logic       eject_ack,
    output logic       busy,
    output logic       eject_q,
    output logic       eject_d,
    output logic       eject_n,
    output logic       done,
    output logic       fault,
    output logic [7:0] dispensed_cents
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EJECT,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_q;
    logic [3:0] r_d;
    logic [3:0] r_n;
    logic [7:0] r_cents;
    logic [7:0] r_tmo;
    logic [3:0] r_gap;

    logic [3:0] w_q_in;
    logic [3:0] w_d_in;
    logic [3:0] w_n_in;
    logic       w_any_in;
    logic       w_any_left;
    logic       w_sel_q;
    logic       w_sel_d;
    logic       w_sel_n;
    logic [7:0] w_coin_value;
    logic [8:0] w_sum;
    logic [7:0] w_cents_next;
    logic       w_gap_last;
    logic       w_tmo_last;

    logic       w_busy;
    logic       w_eject_q;
    logic       w_eject_d;
    logic       w_eject_n;
    logic       w_done;
    logic       w_fault;

    // Counts above 9 (including the upstream blank code 4'b1010) mean "none".
    assign w_q_in   = (q_cnt > 4'd9) ? 4'd0 : q_cnt;
    assign w_d_in   = (d_cnt > 4'd9) ? 4'd0 : d_cnt;
    assign w_n_in   = (n_cnt > 4'd9) ? 4'd0 : n_cnt;
    assign w_any_in = (w_q_in != 4'd0) || (w_d_in != 4'd0) || (w_n_in != 4'd0);

    assign w_any_left = (r_q != 4'd0) || (r_d != 4'd0) || (r_n != 4'd0);
    assign w_sel_q    = (r_q != 4'd0);
    assign w_sel_d    = (r_q == 4'd0) && (r_d != 4'd0);
    assign w_sel_n    = (r_q == 4'd0) && (r_d == 4'd0) && (r_n != 4'd0);

    always_comb begin
        w_coin_value = 8'd0;
        if (w_sel_q) begin
            w_coin_value = 8'd25;
        end else if (w_sel_d) begin
            w_coin_value = 8'd10;
        end else if (w_sel_n) begin
            w_coin_value = 8'd5;
        end
    end

    assign w_sum        = {1'b0, r_cents} + {1'b0, w_coin_value};
    assign w_cents_next = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_gap_last   = (r_gap == GAP_LAST);
    assign w_tmo_last   = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b1;
        w_eject_q = 1'b0;
        w_eject_d = 1'b0;
        w_eject_n = 1'b0;
        w_done    = 1'b0;
        w_fault   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_next = w_any_in ? S_EJECT : S_DONE;
                end
            end
            S_EJECT: begin
                w_eject_q = w_sel_q;
                w_eject_d = w_sel_d;
                w_eject_n = w_sel_n;
                // An ack arriving on the last allowed cycle still counts.
                if (eject_ack) begin
                    w_next = S_GAP;
                end else if (w_tmo_last) begin
                    w_next = S_FAULT;
                end
            end
            S_GAP: begin
                if (w_gap_last) begin
                    w_next = w_any_left ? S_EJECT : S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= 4'd0;
            r_d     <= 4'd0;
            r_n     <= 4'd0;
            r_cents <= 8'd0;
            r_tmo   <= 8'd0;
            r_gap   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q     <= w_q_in;
                        r_d     <= w_d_in;
                        r_n     <= w_n_in;
                        r_cents <= 8'd0;
                        r_tmo   <= 8'd0;
                    end
                end
                S_EJECT: begin
                    if (eject_ack) begin
                        if (w_sel_q) begin
                            r_q <= r_q - 4'd1;
                        end else if (w_sel_d) begin
                            r_d <= r_d - 4'd1;
                        end else if (w_sel_n) begin
                            r_n <= r_n - 4'd1;
                        end
                        r_cents <= w_cents_next;
                        r_gap   <= 4'd0;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_GAP: begin
                    if (w_gap_last) begin
                        r_tmo <= 8'd0;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy            = w_busy;
    assign eject_q         = w_eject_q;
    assign eject_d         = w_eject_d;
    assign eject_n         = w_eject_n;
    assign done            = w_done;
    assign fault           = w_fault;
    assign dispensed_cents = r_cents;

endmodule

// File: tb/tb_coin_dispenser.sv
// tb/tb_coin_dispenser.sv - self-checking bench for coin_dispenser
// Coin-queue reference model compared every cycle, plus directed literal checks.
module tb_coin_dispenser;

    localparam int GAP = 2;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] q_cnt = 4'd0;
    logic [3:0] d_cnt = 4'd0;
    logic [3:0] n_cnt = 4'd0;
    logic       eject_ack = 1'b0;
    logic       busy, eject_q, eject_d, eject_n, done, fault;
    logic [7:0] dispensed_cents;

    coin_dispenser #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt), .eject_ack(eject_ack),
        .busy(busy), .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
        .done(done), .fault(fault), .dispensed_cents(dispensed_cents)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit checking = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    // Reference model: pending coins are a queue of cent values; phases are plain integers.
    localparam int P_IDLE = 0, P_EJECT = 1, P_GAP = 2, P_DONE = 3, P_FAULT = 4;
    int m_phase = P_IDLE;
    int m_coins[$];
    int m_cents = 0;
    int m_waited = 0;
    int m_gap = 0;

    function automatic int legal(input logic [3:0] v);
        return (v > 4'd9) ? 0 : int'(v);
    endfunction

    function automatic int front();
        return (m_coins.size() > 0) ? m_coins[0] : 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = P_IDLE;
            m_coins.delete();
            m_cents = 0;
            m_waited = 0;
            m_gap = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin
                    m_coins.delete();
                    for (int i = 0; i < legal(q_cnt); i++) m_coins.push_back(25);
                    for (int i = 0; i < legal(d_cnt); i++) m_coins.push_back(10);
                    for (int i = 0; i < legal(n_cnt); i++) m_coins.push_back(5);
                    m_cents = 0;
                    m_waited = 0;
                    m_phase = (m_coins.size() > 0) ? P_EJECT : P_DONE;
                end
                P_EJECT: if (eject_ack) begin
                    m_cents = (m_cents + front() > 255) ? 255 : m_cents + front();
                    void'(m_coins.pop_front());
                    m_gap = 0;
                    m_phase = P_GAP;
                end else begin
                    m_waited++;
                    if (m_waited == TMO) m_phase = P_FAULT;
                end
                P_GAP: begin
                    m_gap++;
                    if (m_gap == GAP) begin
                        m_waited = 0;
                        m_phase = (m_coins.size() > 0) ? P_EJECT : P_DONE;
                    end
                end
                P_DONE: m_phase = P_IDLE;
                default: ;
            endcase
        end
    end

    // Observation log for the directed literal checks.
    string seq = "";
    int cents_log[$];
    int done_cnt = 0, done_cyc = -1, busy_after_done = -1, q_hi = 0;
    bit p_q = 0, p_d = 0, p_n = 0, p_done = 0;
    int p_cents = 0;

    task automatic clear_log();
        seq = "";
        cents_log.delete();
        done_cnt = 0;
        done_cyc = -1;
        busy_after_done = -1;
        q_hi = 0;
    endtask

    function automatic int cent_at(input int i);
        return (i < cents_log.size()) ? cents_log[i] : -1;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            logic [13:0] exp_v, act_v;
            exp_v = {m_phase != P_IDLE,
                     m_phase == P_EJECT && front() == 25,
                     m_phase == P_EJECT && front() == 10,
                     m_phase == P_EJECT && front() == 5,
                     m_phase == P_DONE, m_phase == P_FAULT, 8'(m_cents)};
            act_v = {busy, eject_q, eject_d, eject_n, done, fault, dispensed_cents};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_outputs @%0d: got %h expected %h (busy,q,d,n,done,fault,cents)",
                         cyc, act_v, exp_v);
            end
            if (eject_q && !p_q) seq = {seq, "q"};
            if (eject_d && !p_d) seq = {seq, "d"};
            if (eject_n && !p_n) seq = {seq, "n"};
            if (eject_q) q_hi++;
            if (int'(dispensed_cents) > p_cents) cents_log.push_back(int'(dispensed_cents));
            if (p_done && busy_after_done < 0) busy_after_done = int'(busy);
            if (done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            p_q = eject_q; p_d = eject_d; p_n = eject_n; p_done = done;
            p_cents = int'(dispensed_cents);
        end
    end

    // Ack responder: acknowledges on the second cycle an eject line is high.
    bit ack_en = 1, ack_force = 0;
    int hi = 0;
    always @(posedge clk) begin
        #3;
        if (eject_q || eject_d || eject_n) hi++;
        else hi = 0;
        eject_ack = (ack_en && hi >= 2) || ack_force;
    end

    int start_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [3:0] q, input logic [3:0] d, input logic [3:0] n);
        tick();
        start = 1'b1;
        q_cnt = q;
        d_cnt = d;
        n_cnt = n;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        q_cnt = 4'd0;
        d_cnt = 4'd0;
        n_cnt = 4'd0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_completed"}, int'(done_cnt > 0), 1);
        tick();
        tick();
    endtask

    task automatic pulse_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #20;
        checking = 1;
        chk("rst_outputs", int'({busy, eject_q, eject_d, eject_n, done, fault, dispensed_cents}), 0);
        tick();
        reset = 1'b0;

        // Two quarters, a dime and a nickel.
        clear_log();
        do_start(4'd2, 4'd1, 4'd1);
        wait_done("qdn", 200);
        chk_s("qdn_order", seq, "qqdn");
        chk("qdn_cents0", cent_at(0), 25);
        chk("qdn_cents1", cent_at(1), 50);
        chk("qdn_cents2", cent_at(2), 60);
        chk("qdn_cents3", cent_at(3), 65);
        chk("qdn_done_pulses", done_cnt, 1);
        chk("qdn_busy_after_done", busy_after_done, 0);

        // Empty requests: zero counts and blank codes.
        clear_log();
        do_start(4'd0, 4'd0, 4'd0);
        wait_done("zero", 20);
        chk_s("zero_order", seq, "");
        chk("zero_done_latency", done_cyc - start_cyc, 1);
        chk("zero_cents", int'(dispensed_cents), 0);
        clear_log();
        do_start(4'b1010, 4'b1010, 4'b1010);
        wait_done("blank", 20);
        chk_s("blank_order", seq, "");
        chk("blank_done_latency", done_cyc - start_cyc, 1);
        chk("blank_cents", int'(dispensed_cents), 0);

        // Out-of-range counts treated as zero.
        clear_log();
        do_start(4'd15, 4'd11, 4'd3);
        wait_done("clamp", 200);
        chk_s("clamp_order", seq, "nnn");
        chk("clamp_cents", int'(dispensed_cents), 15);

        // Stray ack while idle.
        tick();
        ack_force = 1;
        tick();
        tick();
        ack_force = 0;
        tick();
        chk("stray_ack_busy", int'(busy), 0);

        // Second start during GAP is ignored.
        clear_log();
        do_start(4'd0, 4'd3, 4'd0);
        for (int i = 0; i < 50 && dispensed_cents != 8'd10; i++) tick();
        chk("gap_reached", int'(dispensed_cents), 10);
        start = 1'b1;
        q_cnt = 4'd2;
        tick();
        start = 1'b0;
        q_cnt = 4'd0;
        wait_done("dimes", 200);
        chk_s("dimes_order", seq, "ddd");
        chk("dimes_cents", int'(dispensed_cents), 30);

        // Reset while a nickel eject is high.
        clear_log();
        ack_en = 0;
        do_start(4'd0, 4'd0, 4'd1);
        for (int i = 0; i < 10 && !eject_n; i++) tick();
        chk("nickel_eject_seen", int'(eject_n), 1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("async_reset_eject_n", int'(eject_n), 0);
        chk("async_reset_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        ack_en = 1;
        clear_log();
        do_start(4'd0, 4'd0, 4'd1);
        wait_done("after_reset", 100);
        chk_s("after_reset_order", seq, "n");
        chk("after_reset_cents", int'(dispensed_cents), 5);

        // Ack timeout, sticky fault.
        clear_log();
        ack_en = 0;
        do_start(4'd1, 4'd0, 4'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("timeout_q_high_cycles", q_hi, 8);
        chk("timeout_fault", int'(fault), 1);
        do_start(4'd2, 4'd0, 4'd0);
        ack_force = 1;
        tick();
        ack_force = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("fault_start_ignored", q_hi, 8);
        chk("fault_sticky", int'(fault), 1);
        chk("fault_busy", int'(busy), 1);
        ack_en = 1;
        pulse_reset();
        chk("fault_cleared", int'(fault), 0);

        // Normal operation after recovering from fault.
        clear_log();
        do_start(4'd1, 4'd0, 4'd0);
        wait_done("recover", 100);
        chk_s("recover_order", seq, "q");
        chk("recover_cents", int'(dispensed_cents), 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
